mem_arbiter: RTL

- Two-master, one-slave arbiter for the single memory port in the multi-cycle core.
- Masters are the IFU (read-only instruction fetch) and the LSU (load/store); the slave is the unified SRAM/bus port.
- Serialises one transaction at a time, uses round-robin on contention, and routes each response back to its owner.
- Aborts hung transactions with an error response after a timeout.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter with round-robin grant,
// response routing back to the owner, and a grant-to-response timeout.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  input  logic            ifu_resp_ready,
  output logic [DW-1:0]   ifu_rdata,
  output logic            ifu_resp_err,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  input  logic            lsu_resp_ready,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_resp_err,
  output logic            busy
);

  localparam int MW = DW/8;
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } mreq_t;

  state_t        state;
  mreq_t         req_q, req_d;
  logic          owner;       // 0 = IFU, 1 = LSU
  logic          last_grant;  // same encoding as owner
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gnt_ifu, gnt_lsu, owner_rr, resp_hs, timeout;
  logic          resp_vld, resp_err;
  logic [DW-1:0] resp_data;

  // Reset is folded into the grant so no master sees ready while held in reset.
  always_comb begin
    gnt_ifu = (state == IDLE) && rst && ifu_req_valid && (!lsu_req_valid || last_grant);
    gnt_lsu = (state == IDLE) && rst && lsu_req_valid && (!ifu_req_valid || !last_grant);
    owner_rr = owner ? lsu_resp_ready : ifu_resp_ready;
    resp_hs  = (state == RESP) && mem_resp_valid && owner_rr;
    cnt_nxt  = (cnt == '1) ? cnt : cnt + 1'b1;
    timeout  = (TIMEOUT != 0) && (cnt_nxt >= TO);

    req_d = '0;
    if (gnt_lsu) begin
      req_d.addr  = lsu_addr;
      req_d.wen   = lsu_wen;
      req_d.wdata = lsu_wdata;
      req_d.wmask = lsu_wmask;
    end else begin
      req_d.addr  = ifu_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_q      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_ifu || gnt_lsu) begin
          req_q      <= req_d;
          owner      <= gnt_lsu;
          last_grant <= gnt_lsu;
          cnt        <= '0;
          state      <= REQ;
        end
        REQ: begin
          cnt <= cnt_nxt;
          if (mem_req_ready)  state <= RESP;
          else if (timeout)   state <= ERR;
        end
        RESP: begin
          cnt <= cnt_nxt;
          if (resp_hs)        state <= IDLE;
          else if (timeout)   state <= ERR;
        end
        ERR: if (owner_rr) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    resp_vld  = ((state == RESP) && mem_resp_valid) || (state == ERR);
    resp_err  = (state == ERR) || ((state == RESP) && mem_resp_err);
    resp_data = (state == RESP) ? mem_rdata : '0;

    ifu_req_ready  = gnt_ifu;
    lsu_req_ready  = gnt_lsu;
    ifu_resp_valid = resp_vld && !owner;
    lsu_resp_valid = resp_vld && owner;
    ifu_resp_err   = resp_err && !owner;
    lsu_resp_err   = resp_err && owner;
    ifu_rdata      = owner ? '0 : resp_data;
    lsu_rdata      = owner ? resp_data : '0;

    mem_req_valid  = (state == REQ);
    mem_addr       = req_q.addr;
    mem_wen        = req_q.wen;
    mem_wdata      = req_q.wdata;
    mem_wmask      = req_q.wmask;
    // Idle and error states drain whatever the slave returns.
    case (state)
      IDLE, ERR: mem_resp_ready = 1'b1;
      RESP:      mem_resp_ready = owner_rr;
      default:   mem_resp_ready = 1'b0;
    endcase
    busy = (state != IDLE);
  end

endmodule
